// File: rtl/seq_det_1011_pkg.sv
// seq_det_1011_pkg
// Gives the detector's state encodings a type. The numeric codes come from
// seq_det_defs.vh. Codes 5..7 are deliberately left unnamed. The FSM treats
// them as illegal.
package seq_det_1011_pkg;

`include "seq_det_defs.vh"

  localparam int STATE_W = `SEQ_DET_STATE_W;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = `SEQ_DET_IDLE,   // nothing useful seen yet
    S1    = `SEQ_DET_S1,     // suffix "1"
    S10   = `SEQ_DET_S10,    // suffix "10"
    S101  = `SEQ_DET_S101,   // suffix "101"
    MATCH = `SEQ_DET_MATCH   // full "1011" just seen
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that stops at its maximum value instead of wrapping.
// Ports:
//   Clk - clock
//   rst - asynchronous active-low reset; while low, q = 0
//   clr - synchronous clear; wins over inc on the same edge
//   inc - increment request for this edge
//   q   - count value, W bits
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (inc && (q_reg != '1)) begin
      q_reg <= q_reg + W'(1);
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/seq_det_defs.vh
// seq_det_defs.vh
// State width and state encodings of the 1011 sequence detector. This file
// is included by seq_det_1011_pkg. The RTL and the testbench both import that
// package, so they share these values.
// Only macros are defined here. The include guard makes it safe to pull this
// file in more than once.
`ifndef SEQ_DET_DEFS_VH
`define SEQ_DET_DEFS_VH

`define SEQ_DET_STATE_W 3
`define SEQ_DET_IDLE    3'd0
`define SEQ_DET_S1      3'd1
`define SEQ_DET_S10     3'd2
`define SEQ_DET_S101    3'd3
`define SEQ_DET_MATCH   3'd4

`endif

// File: rtl/seq_det_1011.sv
// seq_det_1011
// Moore FSM that finds the serial pattern 1,0,1,1. The first bit received is
// the first bit of the pattern. Matches may overlap. D is used only on edges
// where en=1. A saturating counter counts how many times MATCH is entered.
// Ports:
//   Clk       - clock; all state changes on its rising edge
//   rst       - asynchronous active-low reset (0 = reset)
//   D         - serial data bit
//   en        - sample qualifier for D
//   cnt_clr   - synchronous clear of match_cnt (does not affect the FSM)
//   match     - high while the FSM is in MATCH; comes straight from a flop
//   match_cnt - number of detections, saturating at 2^CNT_W-1
//   state     - current FSM state code, for debug
module seq_det_1011
  import seq_det_1011_pkg::*;
#(
  parameter int CNT_W = 8  // legal range 2..16
) (
  input  logic               Clk,
  input  logic               rst,
  input  logic               D,
  input  logic               en,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [STATE_W-1:0] state
);

  // The state is held as a plain vector, not the enum type. This way the
  // unused codes 5..7 can exist and the default branch can recover from them.
  logic [STATE_W-1:0] state_reg;
  logic [STATE_W-1:0] state_next;
  logic               match_reg;
  logic               enter_match;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      match_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // match is registered from the next-state decode, so it changes on the
      // same edge as state_reg and has no combinational path from D or en.
      match_reg <= (state_next == MATCH);
    end
  end

  always_comb begin
    state_next  = state_reg;
    enter_match = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en) state_next = D ? S1 : IDLE;
      end
      S1: begin
        if (en) state_next = D ? S1 : S10;
      end
      S10: begin
        if (en) state_next = D ? S101 : IDLE;
      end
      S101: begin
        if (en) begin
          if (D) begin
            state_next  = MATCH;
            enter_match = 1'b1;
          end else begin
            state_next  = S10;
          end
        end
      end
      MATCH: begin
        // The trailing "1" of a match can start a new pattern, and "1"+"0"
        // is the prefix "10". This is how overlapping matches are found.
        if (en) state_next = D ? S1 : S10;
      end
      default: begin
        // Illegal codes go back to IDLE on the next edge, even when en=0.
        state_next = IDLE;
      end
    endcase
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .Clk (Clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (enter_match),
    .q   (match_cnt)
  );

  assign match = match_reg;
  assign state = state_reg;

endmodule

// File: tb/tb_seq_det_1011.sv
// tb_seq_det_1011
// Two detector instances receive the same stimulus: CNT_W=8 and CNT_W=2.
// Directed table rows carry hand-derived expectations for the 8-bit instance.
// A bit-history reference model predicts both instances every cycle. The
// expected values go into a scoreboard queue when the stimulus is driven, and
// are popped and compared 1 ns after the clock edge.
module tb_seq_det_1011;
  import seq_det_1011_pkg::*;

  logic       Clk = 1'b0;
  logic       rst = 1'b0;
  logic       D = 1'b0;
  logic       en = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       match8;
  logic [7:0] cnt8;
  logic [2:0] state8;
  logic       match2;
  logic [1:0] cnt2;
  logic [2:0] state2;

  always #5 Clk = ~Clk;

  seq_det_1011 #(.CNT_W(8)) dut8 (
    .Clk       (Clk),
    .rst       (rst),
    .D         (D),
    .en        (en),
    .cnt_clr   (cnt_clr),
    .match     (match8),
    .match_cnt (cnt8),
    .state     (state8)
  );

  seq_det_1011 #(.CNT_W(2)) dut2 (
    .Clk       (Clk),
    .rst       (rst),
    .D         (D),
    .en        (en),
    .cnt_clr   (cnt_clr),
    .match     (match2),
    .match_cnt (cnt2),
    .state     (state2)
  );

  typedef struct {
    logic       en;
    logic       d;
    logic       clr;
    logic       exp_m;
    int         exp_cnt;
    logic [2:0] exp_st;
  } vec_t;

  typedef struct {
    logic       m8;
    int         cnt8;
    logic [2:0] st8;
    logic       m2;
    int         cnt2;
    logic [2:0] st2;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int checks = 0;
  int passed = 0;
  int step_no = 0;

  // Reference model: the last four sampled bits, plus one saturating
  // counter per instance.
  logic [3:0] hist = 4'b0000;
  int         mcnt8 = 0;
  int         mcnt2 = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s step %0d: got %0d expected %0d", name, step_no, act, exp);
  endtask

  // The state is the longest suffix of the history that is also a prefix of 1011.
  function automatic logic [2:0] model_state(input logic [3:0] h);
    if (h == 4'b1011)      return MATCH;
    if (h[2:0] == 3'b101)  return S101;
    if (h[1:0] == 2'b10)   return S10;
    if (h[0])              return S1;
    return IDLE;
  endfunction

  task automatic add(input logic e, input logic d, input logic c,
                     input logic m, input int cnt, input logic [2:0] st);
    vec_t v;
    v.en = e; v.d = d; v.clr = c; v.exp_m = m; v.exp_cnt = cnt; v.exp_st = st;
    vecs.push_back(v);
  endtask

  // Apply one clock of stimulus. If use_tbl is set, the 8-bit instance is
  // checked against the given expectations. Otherwise the model is used.
  task automatic step(input logic e, input logic d, input logic c, input logic use_tbl,
                      input logic em, input int ec, input logic [2:0] es);
    exp_t x;
    logic hit;
    en = e; D = d; cnt_clr = c;
    if (e) hist = {hist[2:0], d};
    hit = e && (hist == 4'b1011);
    if (c) begin
      mcnt8 = 0; mcnt2 = 0;
    end else if (hit) begin
      if (mcnt8 < 255) mcnt8++;
      if (mcnt2 < 3) mcnt2++;
    end
    x.m2 = (hist == 4'b1011);
    x.cnt2 = mcnt2;
    x.st2 = model_state(hist);
    x.m8 = use_tbl ? em : x.m2;
    x.cnt8 = use_tbl ? ec : mcnt8;
    x.st8 = use_tbl ? es : x.st2;
    sb.push_back(x);
    @(posedge Clk);
    #1;
    step_no++;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      x = sb.pop_front();
      check("match8", int'(match8), int'(x.m8));
      check("cnt8", int'(cnt8), x.cnt8);
      check("state8", int'(state8), int'(x.st8));
      check("match2", int'(match2), int'(x.m2));
      check("cnt2", int'(cnt2), x.cnt2);
      check("state2", int'(state2), int'(x.st2));
    end
    $display("step %0d en=%0b D=%0b clr=%0b -> match=%0b cnt8=%0d cnt2=%0d state=%0d",
             step_no, e, d, c, match8, cnt8, cnt2, state8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic detection 1,0,1,1, then leave the pattern.
    add(1,1,0, 0,0,S1);   add(1,0,0, 0,0,S10);  add(1,1,0, 0,0,S101);
    add(1,1,0, 1,1,MATCH);add(1,0,0, 0,1,S10);  add(1,0,0, 0,1,IDLE);
    // Back-to-back overlapping 1011011.
    add(1,1,0, 0,1,S1);   add(1,0,0, 0,1,S10);  add(1,1,0, 0,1,S101);
    add(1,1,0, 1,2,MATCH);add(1,0,0, 0,2,S10);  add(1,1,0, 0,2,S101);
    add(1,1,0, 1,3,MATCH);add(1,0,0, 0,3,S10);  add(1,0,0, 0,3,IDLE);
    // 1,0, then en=0 for three edges, then 1,1. Then en=0 holds MATCH, and
    // cnt_clr clears the count without disturbing the FSM.
    add(1,1,0, 0,3,S1);   add(1,0,0, 0,3,S10);
    add(0,0,0, 0,3,S10);  add(0,0,0, 0,3,S10);  add(0,0,0, 0,3,S10);
    add(1,1,0, 0,3,S101); add(1,1,0, 1,4,MATCH);
    add(0,0,0, 1,4,MATCH);add(0,1,0, 1,4,MATCH);add(0,1,1, 1,0,MATCH);
    add(1,1,0, 0,0,S1);   add(1,0,0, 0,0,S10);
    // Reach a count of 2, then clear on the edge that enters MATCH.
    add(1,1,0, 0,0,S101); add(1,1,0, 1,1,MATCH);add(1,0,0, 0,1,S10);
    add(1,1,0, 0,1,S101); add(1,1,0, 1,2,MATCH);add(1,0,0, 0,2,S10);
    add(1,1,0, 0,2,S101); add(1,1,1, 1,0,MATCH);add(1,0,0, 0,0,S10);
    // Nonzero count, then a partial 1,0,1 before the reset pulse.
    add(1,1,0, 0,0,S101); add(1,1,0, 1,1,MATCH);add(1,0,0, 0,1,S10);
    add(1,0,0, 0,1,IDLE); add(1,1,0, 0,1,S1);   add(1,0,0, 0,1,S10);
    add(1,1,0, 0,1,S101);

    // Reset is held from t=0. Check the state before any clock edge.
    #1;
    check("rst_state", int'(state8), int'(IDLE));
    check("rst_match", int'(match8), 0);
    check("rst_cnt", int'(cnt8), 0);
    $display("reset t=1 state=%0d match=%0b cnt=%0d", state8, match8, cnt8);
    #1 rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].en, vecs[i].d, vecs[i].clr, 1'b1,
           vecs[i].exp_m, vecs[i].exp_cnt, vecs[i].exp_st);

    // Reset between edges, after the partial 101: the effect must be immediate.
    @(negedge Clk);
    rst = 1'b0;
    #1;
    check("midrst_state", int'(state8), int'(IDLE));
    check("midrst_match", int'(match8), 0);
    check("midrst_cnt8", int'(cnt8), 0);
    check("midrst_cnt2", int'(cnt2), 0);
    $display("mid-stream reset state=%0d match=%0b cnt8=%0d", state8, match8, cnt8);
    hist = 4'b0000; mcnt8 = 0; mcnt2 = 0;
    #2 rst = 1'b1;
    // A lone 1 after release must not complete the discarded 101.
    step(1,1,0, 1'b1, 0,0,S1);

    // Five overlapping detections: 1 already sent, then (0,1,1) x5.
    for (int k = 0; k < 5; k++) begin
      step(1,0,0, 1'b0, 0,0,IDLE);
      step(1,1,0, 1'b0, 0,0,IDLE);
      step(1,1,0, 1'b0, 0,0,IDLE);
    end
    check("sat_cnt8", int'(cnt8), 5);
    check("sat_cnt2", int'(cnt2), 3);
    $display("after five detections cnt8=%0d cnt2=%0d", cnt8, cnt2);

    // Random traffic, predicted by the model.
    for (int k = 0; k < 200; k++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 1'b0, 0, 0, IDLE);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
